// File: rtl/binary_erosion.sv
// 3x3 binary erosion on a streamed 1-bit image, 2-clk latency through sync/de/pixel.
// Build option: define BINARY_MORPH_DILATE_EN to get 3x3 dilation instead (OR, pad with 0).
module binary_erosion #(
    parameter int unsigned IMG_WIDTH = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pre_vsync,
    input  logic pre_hsync,
    input  logic pre_de,
    input  logic pre_monoc,
    output logic post_vsync,
    output logic post_hsync,
    output logic post_de,
    output logic post_monoc
);

`ifdef BINARY_MORPH_DILATE_EN
    localparam logic Neutral = 1'b0;
`else
    localparam logic Neutral = 1'b1;
`endif

    localparam logic [ADDR_W-1:0] ColLast = ADDR_W'(IMG_WIDTH - 1);

    logic              buf0 [IMG_WIDTH];
    logic              buf1 [IMG_WIDTH];
    logic [ADDR_W-1:0] col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic              full_q, full_d;
    logic              de_q, vs_q, hs_q;
    logic              vs_rise, hs_rise, line_end;
    logic [1:0]        row_eff;
    logic              rd0, rd1;
    logic [2:0]        new_col;
    logic [2:0]        win_q [3];
    logic              c0_q, c1_q;
    logic              de_s1, vs_s1, hs_s1;
    logic [2:0]        w0, w1;
    logic              result;

    assign vs_rise = pre_vsync & ~vs_q;
    assign hs_rise = pre_hsync & ~hs_q;
    // A de gap only ends the line once it is full, so gaps inside a line stay
    // transparent; an hsync edge closes a short line.
    assign line_end = ~pre_de & ((de_q & full_q) | (hs_rise & (full_q | (col_q != '0))));
    assign row_eff  = vs_rise ? 2'd0 : row_q;

    assign rd0     = buf0[col_q];
    assign rd1     = buf1[col_q];
    assign new_col = {(row_eff == 2'd2) ? rd1 : Neutral,
                      (row_eff != 2'd0) ? rd0 : Neutral,
                      pre_monoc};

    always_comb begin
        col_d  = col_q;
        full_d = full_q;
        row_d  = row_q;
        if (pre_de) begin
            if (col_q == ColLast) full_d = 1'b1;
            else                  col_d  = col_q + 1'b1;
        end else if (line_end) begin
            col_d  = '0;
            full_d = 1'b0;
        end
        if (vs_rise)                          row_d = 2'd0;
        else if (line_end && row_q != 2'd2)   row_d = row_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            full_q <= 1'b0;
            de_q   <= 1'b0;
            vs_q   <= 1'b0;
            hs_q   <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            full_q <= full_d;
            de_q   <= pre_de;
            vs_q   <= pre_vsync;
            hs_q   <= pre_hsync;
        end
    end

    // Line buffers: not reset; stale contents are masked by the row counter.
    always_ff @(posedge clk) begin
        if (pre_de) begin
            buf1[col_q] <= buf0[col_q];
            buf0[col_q] <= pre_monoc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q[0] <= '0;
            win_q[1] <= '0;
            win_q[2] <= '0;
            c0_q     <= 1'b0;
            c1_q     <= 1'b0;
            de_s1    <= 1'b0;
            vs_s1    <= 1'b0;
            hs_s1    <= 1'b0;
        end else begin
            de_s1 <= pre_de;
            vs_s1 <= pre_vsync;
            hs_s1 <= pre_hsync;
            if (pre_de) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= new_col;
                c0_q     <= (col_q == '0);
                c1_q     <= (col_q == ADDR_W'(1));
            end
        end
    end

    // Columns left of the frame edge are replaced by the neutral value.
    always_comb begin
        w0 = (c0_q | c1_q) ? {3{Neutral}} : win_q[0];
        w1 = c0_q ? {3{Neutral}} : win_q[1];
`ifdef BINARY_MORPH_DILATE_EN
        result = |{w0, w1, win_q[2]};
`else
        result = &{w0, w1, win_q[2]};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_vsync <= 1'b0;
            post_hsync <= 1'b0;
            post_de    <= 1'b0;
            post_monoc <= 1'b0;
        end else begin
            post_vsync <= vs_s1;
            post_hsync <= hs_s1;
            post_de    <= de_s1;
            post_monoc <= de_s1 & result;
        end
    end

endmodule

// File: tb/tb_binary_erosion.sv
// Self-checking bench for binary_erosion: 8x6 frames, scoreboard of expected pixels
// computed from a reference image model.
module tb_binary_erosion;
    localparam int W = 8;
    localparam int H = 6;

`ifdef BINARY_MORPH_DILATE_EN
    localparam bit Dilate = 1'b1;
`else
    localparam bit Dilate = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pre_vsync = 1'b0, pre_hsync = 1'b0, pre_de = 1'b0, pre_monoc = 1'b0;
    logic post_vsync, post_hsync, post_de, post_monoc;

    int errors = 0;
    int checks = 0;
    int pops = 0;
    bit exp_q[$];
    bit img[H][W];
    bit h_de[2], h_vs[2], h_hs[2];

    always #5 clk = ~clk;

    binary_erosion #(.IMG_WIDTH(W), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pre_vsync (pre_vsync),
        .pre_hsync (pre_hsync),
        .pre_de    (pre_de),
        .pre_monoc (pre_monoc),
        .post_vsync(post_vsync),
        .post_hsync(post_hsync),
        .post_de   (post_de),
        .post_monoc(post_monoc)
    );

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic bit model(input int r, input int c);
        bit acc = !Dilate;
        bit v;
        for (int rr = r - 2; rr <= r; rr++) begin
            for (int cc = c - 2; cc <= c; cc++) begin
                v = (rr < 0 || cc < 0) ? !Dilate : img[rr][cc];
                acc = Dilate ? (acc | v) : (acc & v);
            end
        end
        return acc;
    endfunction

    task automatic fill(input bit v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = v;
    endtask

    task automatic clear_model();
        exp_q.delete();
        pops = 0;
        h_de = '{0, 0};
        h_vs = '{0, 0};
        h_hs = '{0, 0};
    endtask

    // One clock: drive inputs, then check outputs against those driven two clocks earlier.
    task automatic step(input bit vs, input bit hs, input bit de, input bit m, input bit e);
        @(posedge clk);
        #1;
        pre_vsync = vs;
        pre_hsync = hs;
        pre_de    = de;
        pre_monoc = m;
        @(negedge clk);
        chk("post_de_latency", post_de, h_de[1]);
        chk("post_vsync_latency", post_vsync, h_vs[1]);
        chk("post_hsync_latency", post_hsync, h_hs[1]);
        if (post_de === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk_int("scoreboard_underflow", 1, 0);
            end else begin
                chk("pixel", post_monoc, exp_q.pop_front());
                pops++;
            end
        end else begin
            chk("monoc_idle_zero", post_monoc, 1'b0);
        end
        h_de[1] = h_de[0]; h_de[0] = de;
        h_vs[1] = h_vs[0]; h_vs[0] = vs;
        h_hs[1] = h_hs[0]; h_hs[0] = hs;
        if (de) exp_q.push_back(e);
    endtask

    task automatic reset_pulse(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        pre_vsync = 0; pre_hsync = 0; pre_de = 0; pre_monoc = 0;
        clear_model();
        #1;
        chk("rst_post_de", post_de, 1'b0);
        chk("rst_post_monoc", post_monoc, 1'b0);
        chk("rst_post_vsync", post_vsync, 1'b0);
        chk("rst_post_hsync", post_hsync, 1'b0);
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input bit toggle, input int abort_r, input int abort_c);
        repeat (2) step(1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        for (int r = 0; r < H; r++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            for (int c = 0; c < W; c++) begin
                if (r == abort_r && c == abort_c) begin
                    reset_pulse(3);
                    return;
                end
                step(0, 0, 1, img[r][c], model(r, c));
                if (toggle) step(0, 0, 0, 0, 0);
            end
            repeat (2) step(0, 0, 0, 0, 0);
        end
        repeat (3) step(0, 0, 0, 0, 0);
        chk_int("frame_pixel_count", pops, H * W);
        chk_int("scoreboard_empty", exp_q.size(), 0);
        pops = 0;
    endtask

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_post_de", post_de, 1'b0);
        chk("reset_post_monoc", post_monoc, 1'b0);
        chk("reset_post_vsync", post_vsync, 1'b0);
        chk("reset_post_hsync", post_hsync, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        fill(1);                      // all-ones frame
        run_frame(0, -1, -1);

        fill(1); img[2][3] = 0;       // single interior hole
        run_frame(0, -1, -1);

        fill(1); img[0][0] = 0;       // corner hole, frame edges padded
        run_frame(0, -1, -1);

        fill(0);                      // reset mid-frame leaves zeros in buffers
        run_frame(0, 3, 4);
        fill(1);
        run_frame(0, -1, -1);

        fill(1); img[2][3] = 0;       // de toggling every clock
        run_frame(1, -1, -1);

        fill(0); img[2][3] = 1;       // single foreground pixel
        run_frame(0, -1, -1);

        for (int r = 0; r < H; r++)   // mostly-ones random pattern
            for (int c = 0; c < W; c++) img[r][c] = ($urandom_range(0, 7) != 0);
        run_frame(0, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
